instruction_loader: RTL

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader_pkg.sv | 21 ++
 rtl/instruction_loader_word_assembler.sv | 44 ++++
 rtl/instruction_loader.sv | 116 +++++++++++
 3 files changed

// File: rtl/instruction_loader_pkg.sv
// ============================================================================
// Module      : instruction_loader_pkg
// Description : FSM encoding and shared constants for the instruction loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int          BYTES_PER_WORD    = 4;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/instruction_loader_word_assembler.sv
// ============================================================================
// Module      : word_assembler
// Description : Shifts received bytes MSB-first into a word; pulses word_ready
//               alongside the byte that completes it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_assembler
  import instruction_loader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [7:0]       byte_in,
  output logic [WIDTH-1:0] word,
  output logic             word_ready
);

  logic [WIDTH-9:0] shift;
  logic [1:0]       idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift <= '0;
      idx   <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (shift_en) begin
      shift <= {shift[WIDTH-17:0], byte_in};
      idx   <= idx + 2'd1;
    end
  end

  // The completing byte is merged combinationally so the top can register the write on this edge.
  assign word       = {shift, byte_in};
  assign word_ready = shift_en && (idx == 2'(BYTES_PER_WORD - 1));

endmodule

`default_nettype wire

// File: rtl/instruction_loader.sv
// ============================================================================
// Module      : instruction_loader
// Description : Loads a byte stream into instruction RAM as word writes, stops
//               on HALT_WORD or a full RAM. Optional XOR checksum enabled by
//               macro LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int             len       = 32,
  parameter int             RAM_DEPTH = 2048,
  parameter logic [len-1:0] HALT_WORD = len'(HALT_WORD_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_start,
  input  logic [7:0]                 in_byte,
  input  logic                       in_byte_valid,
  output logic                       out_wr_en,
  output logic [len-1:0]             out_wr_addr,
  output logic [len-1:0]             out_wr_data,
  output logic                       out_busy,
  output logic                       out_done,
  output logic [$clog2(RAM_DEPTH):0] out_word_count,
  output logic [len-1:0]             out_checksum
);

  localparam int             CNT_W     = $clog2(RAM_DEPTH) + 1;
  localparam logic [len-1:0] LAST_ADDR = len'(BYTES_PER_WORD * (RAM_DEPTH - 1));
  localparam logic [len-1:0] ADDR_STEP = len'(BYTES_PER_WORD);

  state_t         state;
  state_t         state_next;
  logic           start_ok;
  logic           byte_ok;
  logic           word_ready;
  logic           last_word;
  logic [len-1:0] word;
  logic           busy_next;
  logic           done_next;

  assign start_ok  = in_start && (state != ST_LOAD);
  assign byte_ok   = in_byte_valid && (state == ST_LOAD);
  assign last_word = (word == HALT_WORD) || (out_wr_addr == LAST_ADDR);

  word_assembler #(
    .WIDTH(len)
  ) u_word_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .shift_en  (byte_ok),
    .byte_in   (in_byte),
    .word      (word),
    .word_ready(word_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: if (in_start) state_next = ST_LOAD;
      ST_LOAD:          if (word_ready && last_word) state_next = ST_DONE;
      default:          state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_next = (state_next == ST_LOAD);
    done_next = (state_next == ST_DONE);
  end

  // Address steps one cycle after the write so out_wr_addr shows the written slot during the strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_wr_en      <= 1'b0;
      out_wr_addr    <= '0;
      out_wr_data    <= '0;
      out_busy       <= 1'b0;
      out_done       <= 1'b0;
      out_word_count <= '0;
    end else begin
      out_busy  <= busy_next;
      out_done  <= done_next;
      out_wr_en <= word_ready;
      if (word_ready) out_wr_data <= word;
      if (start_ok) begin
        out_wr_addr    <= '0;
        out_word_count <= '0;
      end else begin
        if (word_ready) out_word_count <= out_word_count + CNT_W'(1);
        if (out_wr_en && (out_wr_addr != LAST_ADDR)) out_wr_addr <= out_wr_addr + ADDR_STEP;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           out_checksum <= '0;
    else if (start_ok)   out_checksum <= '0;
    else if (word_ready) out_checksum <= out_checksum ^ word;
  end
`else
  assign out_checksum = '0;
`endif

endmodule

`default_nettype wire
